// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and byte-merge helper for the register file
package regfile_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int NUM_READ_DEF   = 2;

  // Merge helper works on a fixed wide word; callers size-cast in and out.
  localparam int MERGE_WIDTH = 256;
  localparam int MERGE_BYTES = MERGE_WIDTH / 8;

  function automatic logic [MERGE_WIDTH-1:0] byte_merge(
    input logic [MERGE_WIDTH-1:0] old_word,
    input logic [MERGE_WIDTH-1:0] new_word,
    input logic [MERGE_BYTES-1:0] be
  );
    logic [MERGE_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < MERGE_BYTES; i++) begin
      if (be[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational read port: lookup, bypass, zero mask, busy
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic [ADDR_WIDTH-1:0]                   addr,
  input  logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]   mem_flat,
  input  logic [(2**ADDR_WIDTH)-1:0]              busy_vec,
  input  logic                                    wr0_hit,
  input  logic [ADDR_WIDTH-1:0]                   wr0_addr,
  input  logic [DATA_WIDTH-1:0]                   wr0_data,
  input  logic [DATA_WIDTH/8-1:0]                 wr0_be,
  input  logic                                    wr1_hit,
  input  logic [ADDR_WIDTH-1:0]                   wr1_addr,
  input  logic [DATA_WIDTH-1:0]                   wr1_data,
  output logic [DATA_WIDTH-1:0]                   rd_data,
  output logic                                    rd_busy
);

  logic                  addr_zero;
  logic [DATA_WIDTH-1:0] word;

  assign addr_zero = ZERO_REG && (addr == '0);

  // Present the value the register will hold after this edge.
  always_comb begin
    word = mem_flat[int'(addr)*DATA_WIDTH +: DATA_WIDTH];
    if (wr0_hit && (wr0_addr == addr)) begin
      word = DATA_WIDTH'(byte_merge(MERGE_WIDTH'(word), MERGE_WIDTH'(wr0_data),
                                    MERGE_BYTES'(wr0_be)));
    end
    if (wr1_hit && (wr1_addr == addr)) word = wr1_data;
    if (addr_zero) word = '0;
  end

  assign rd_data = word;
  assign rd_busy = !addr_zero && busy_vec[addr];

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with two write ports, bypass and load scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_READ   = NUM_READ_DEF,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_READ-1:0]            rd_busy,
  input  logic                           wr0_en,
  input  logic [ADDR_WIDTH-1:0]          wr0_addr,
  input  logic [DATA_WIDTH-1:0]          wr0_data,
  input  logic [DATA_WIDTH/8-1:0]        wr0_be,
  input  logic                           wr1_en,
  input  logic [ADDR_WIDTH-1:0]          wr1_addr,
  input  logic [DATA_WIDTH-1:0]          wr1_data,
  input  logic                           busy_set,
  input  logic [ADDR_WIDTH-1:0]          busy_addr,
  output logic [ADDR_WIDTH:0]            busy_count
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0]       mem [DEPTH];
  logic [DEPTH*DATA_WIDTH-1:0] mem_flat;
  logic [DEPTH-1:0]            busy;
  logic [DEPTH-1:0]            busy_nxt;
  logic [ADDR_WIDTH:0]         count_nxt;
  logic                        wr0_hit;
  logic                        wr1_hit;
  logic                        set_hit;
  logic                        set_rise;
  logic                        clr_fall;

  // wr1 owns the whole word on a collision, so wr0 is dropped up front.
  assign wr0_hit = wr0_en && (|wr0_be) && !(ZERO_REG && (wr0_addr == '0))
                   && !(wr1_en && (wr1_addr == wr0_addr));
  assign wr1_hit = wr1_en && !(ZERO_REG && (wr1_addr == '0));
  assign set_hit = busy_set && !(ZERO_REG && (busy_addr == '0));

  always_comb begin
    busy_nxt = busy;
    if (wr1_hit) busy_nxt[wr1_addr] = 1'b0;
    if (set_hit) busy_nxt[busy_addr] = 1'b1;
  end

  // At most one bit can rise and one can fall per edge, so the count moves by one.
  assign set_rise = set_hit && !busy[busy_addr];
  assign clr_fall = wr1_hit && busy[wr1_addr] && !(set_hit && (busy_addr == wr1_addr));

  always_comb begin
    count_nxt = busy_count;
    if (set_rise && !clr_fall) count_nxt = busy_count + COUNT_ONE;
    if (clr_fall && !set_rise) count_nxt = busy_count - COUNT_ONE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (wr0_hit) begin
        mem[wr0_addr] <= DATA_WIDTH'(byte_merge(MERGE_WIDTH'(mem[wr0_addr]),
                                                MERGE_WIDTH'(wr0_data),
                                                MERGE_BYTES'(wr0_be)));
      end
      if (wr1_hit) mem[wr1_addr] <= wr1_data;
      busy       <= busy_nxt;
      busy_count <= count_nxt;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign mem_flat[i*DATA_WIDTH +: DATA_WIDTH] = mem[i];
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_port
    regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG)
    ) u_port (
      .addr     (rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .mem_flat (mem_flat),
      .busy_vec (busy),
      .wr0_hit  (wr0_hit),
      .wr0_addr (wr0_addr),
      .wr0_data (wr0_data),
      .wr0_be   (wr0_be),
      .wr1_hit  (wr1_hit),
      .wr1_addr (wr1_addr),
      .wr1_data (wr1_data),
      .rd_data  (rd_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .rd_busy  (rd_busy[k])
    );
  end

endmodule
